// File: rtl/misc64_pkg.sv
// Shared MISC64 instruction-format definitions used by fetch and decode.
package misc64_pkg;

  localparam int unsigned LONG_W   = 64;
  localparam int unsigned CIMM_LSB = 0;   // compare-immediate field [1:0]
  localparam int unsigned OIMM_LSB = 62;  // operand-immediate field [63:62]
  localparam int unsigned WIN_N    = 5;   // longs presented to the decoder
  localparam int unsigned LEN_W    = 4;

  // Instruction length in longs (1..5) from its first long.
  function automatic logic [LEN_W-1:0] inst_length(input logic [LONG_W-1:0] l);
    logic [1:0] w_c;
    logic [1:0] w_o;
    w_c = l[CIMM_LSB +: 2];
    w_o = l[OIMM_LSB +: 2];
    return LEN_W'(1) + LEN_W'(w_c[0]) + LEN_W'(w_c[1])
                     + LEN_W'(w_o[0]) + LEN_W'(w_o[1]);
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Circular long buffer: one write port, five read taps at head+0..4,
// variable-length pop. Taps beyond the current count read as zero.
module fetch_queue
  import misc64_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_clear,
  input  logic                         i_push,
  input  logic [LONG_W-1:0]            i_wdata,
  input  logic                         i_pop,
  input  logic [LEN_W-1:0]             i_pop_len,
  output logic [WIN_N-1:0][LONG_W-1:0] o_taps,
  output logic [CNT_W-1:0]             o_count
);

  logic [LONG_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;

  // Head/tail pointers and occupancy; clear wins over push and pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (i_clear) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_tail <= r_tail + PTR_W'(1);
      if (i_pop)  r_head <= r_head + PTR_W'(i_pop_len);
      r_count <= r_count + CNT_W'(i_push) - (i_pop ? CNT_W'(i_pop_len) : '0);
    end
  end

  // Entry storage; contents outside head..head+count-1 are never observed.
  always_ff @(posedge clk) begin
    if (i_push && !i_clear) r_mem[r_tail] <= i_wdata;
  end

  // Read taps wrap modulo DEPTH; taps past the occupancy are forced to zero.
  always_comb begin
    o_taps = '0;
    for (int unsigned i = 0; i < WIN_N; i++) begin
      if (CNT_W'(i) < r_count) o_taps[i] = r_mem[r_head + PTR_W'(i)];
    end
  end

  assign o_count = r_count;

  // Occupancy must never underflow or overflow.
  always_ff @(posedge clk) begin
    if (rst_n && !i_clear) begin
      assert (!i_pop || (CNT_W'(i_pop_len) <= r_count));
      assert (!i_push || i_pop || (r_count < CNT_W'(DEPTH)));
    end
  end

endmodule

// File: rtl/fetch_window.sv
// Instruction fetch window: credit-limited sequential fetch into a circular
// queue, five-long window to the decoder, flush with stale-response discard.
module fetch_window
  import misc64_pkg::*;
#(
  parameter int unsigned       DEPTH    = 8,
  parameter logic [LONG_W-1:0] RESET_PC = '0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic [LONG_W-1:0]            flush_pc,
  output logic                         req_valid,
  output logic [LONG_W-1:0]            req_addr,
  input  logic                         req_ready,
  input  logic                         rsp_valid,
  input  logic [LONG_W-1:0]            rsp_data,
  output logic [WIN_N-1:0][LONG_W-1:0] longs,
  output logic                         win_valid,
  output logic [LEN_W-1:0]             win_len,
  output logic [LONG_W-1:0]            win_pc,
  input  logic                         win_ready
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [LONG_W-1:0] r_fetch_pc;
  logic [LONG_W-1:0] r_win_pc;
  logic [CNT_W-1:0]  r_outst;
  logic [CNT_W-1:0]  r_discard;

  logic [CNT_W-1:0]  w_count;
  logic [LEN_W-1:0]  w_len;
  logic              w_win_valid;
  logic              w_credit_ok;
  logic              w_fire;
  logic              w_push;
  logic              w_pop;

  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clear   (flush),
    .i_push    (w_push),
    .i_wdata   (rsp_data),
    .i_pop     (w_pop),
    .i_pop_len (w_len),
    .o_taps    (longs),
    .o_count   (w_count)
  );

  assign w_len       = inst_length(longs[0]);
  assign w_win_valid = (w_count >= CNT_W'(w_len));
  assign w_credit_ok = ({1'b0, w_count} + {1'b0, r_outst}) < (CNT_W + 1)'(DEPTH);
  assign req_valid   = rst_n && !flush && w_credit_ok;
  assign req_addr    = r_fetch_pc;
  assign w_fire      = req_valid && req_ready;
  assign w_push      = rsp_valid && !flush && (r_discard == '0);
  assign w_pop       = w_win_valid && win_ready && !flush;

  assign win_valid   = w_win_valid;
  assign win_len     = w_len;
  assign win_pc      = r_win_pc;

  // Fetch/window PCs and in-flight accounting; flush overrides everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc <= RESET_PC;
      r_win_pc   <= RESET_PC;
      r_outst    <= '0;
      r_discard  <= '0;
    end else if (flush) begin
      r_fetch_pc <= flush_pc;
      r_win_pc   <= flush_pc;
      r_outst    <= r_outst - CNT_W'(rsp_valid);
      // Stale entries are a subset of outst, so every fetch still in flight
      // after this cycle's response becomes stale (covers repeated flushes).
      r_discard  <= r_outst - CNT_W'(rsp_valid);
    end else begin
      if (w_fire) r_fetch_pc <= r_fetch_pc + LONG_W'(8);
      if (w_pop)  r_win_pc   <= r_win_pc + LONG_W'({w_len, 3'b000});
      r_outst <= r_outst + CNT_W'(w_fire) - CNT_W'(rsp_valid);
      if (rsp_valid && (r_discard != '0)) r_discard <= r_discard - CNT_W'(1);
    end
  end

  // Credit and response accounting must stay within bounds.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!rsp_valid || (r_outst != '0));
      assert (r_discard <= r_outst);
      assert (({1'b0, w_count} + {1'b0, r_outst}) <= (CNT_W + 1)'(DEPTH));
    end
  end

endmodule

// File: tb/tb_fetch_window.sv
// Bench for fetch_window: in-order memory model plus a queue-level reference
// of the instruction window, directed phases followed by randomized traffic.
module tb_fetch_window;

  localparam int unsigned DEPTH    = 8;
  localparam logic [63:0] RESET_PC = 64'h0;

  logic            clk = 1'b0;
  logic            rst_n, flush, req_ready, rsp_valid, win_ready;
  logic            req_valid, win_valid;
  logic [63:0]     flush_pc, req_addr, rsp_data, win_pc;
  logic [4:0][63:0] longs;
  logic [3:0]      win_len;

  fetch_window #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .flush_pc(flush_pc),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .longs(longs), .win_valid(win_valid), .win_len(win_len), .win_pc(win_pc),
    .win_ready(win_ready)
  );

  always #5 clk = ~clk;

  typedef struct { logic [63:0] addr; bit stale; int due; } fl_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  fl_t         inflight[$];
  logic [63:0] q[$];
  logic [63:0] m_fetch_pc, m_win_pc;
  int          cyc, lat, ready_pct, rsp_pct, wr_pct;
  int          first_wv_cyc = -1;
  bit          e_rv, e_wv;
  logic [3:0]  e_len;

  // Program image: region 0 all length-1, region 1 all length-5, else mixed.
  function automatic logic [63:0] word_at(input logic [63:0] a);
    logic [63:0] h;
    h = {a[31:0] ^ 32'h9E3779B9, a[31:0] * 32'h85EBCA6B + 32'hC2B2AE35};
    case (a[15:12])
      4'h0:    begin h[1:0] = 2'b00; h[63:62] = 2'b00; end
      4'h1:    begin h[1:0] = 2'b11; h[63:62] = 2'b11; end
      default: ;
    endcase
    return h;
  endfunction

  function automatic logic [3:0] ref_len(input logic [63:0] w);
    return 4'(1 + $countones(w[1:0]) + $countones(w[63:62]));
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit do_flush, input logic [63:0] fpc);
    flush     = do_flush;
    flush_pc  = fpc;
    req_ready = ($urandom_range(0, 99) < ready_pct);
    rsp_valid = (inflight.size() > 0) && (inflight[0].due <= cyc) &&
                ($urandom_range(0, 99) < rsp_pct);
    rsp_data  = rsp_valid ? word_at(inflight[0].addr) : {$urandom, $urandom};
    win_ready = ($urandom_range(0, 99) < wr_pct);
  endtask

  task automatic check_outputs();
    int n;
    n     = q.size();
    e_rv  = rst_n && !flush && (n + inflight.size() < DEPTH);
    e_len = (n > 0) ? ref_len(q[0]) : 4'd1;
    e_wv  = (n >= int'(e_len));
    chk("req_valid", req_valid, e_rv);
    if (e_rv) chk("req_addr", req_addr, m_fetch_pc);
    chk("win_len", win_len, e_len);
    chk("win_valid", win_valid, e_wv);
    chk("win_pc", win_pc, m_win_pc);
    for (int i = 0; i < 5; i++) chk($sformatf("longs%0d", i), longs[i], (i < n) ? q[i] : 64'h0);
    if (n > 0) chk("longs0_image", longs[0], word_at(m_win_pc));
    if (win_valid === 1'b1 && first_wv_cyc < 0) first_wv_cyc = cyc;
  endtask

  task automatic update_model();
    fl_t e;
    if (!rst_n) return;
    if (flush) begin
      q.delete();
      m_fetch_pc = flush_pc;
      m_win_pc   = flush_pc;
      if (rsp_valid) void'(inflight.pop_front());
      foreach (inflight[i]) inflight[i].stale = 1'b1;
    end else begin
      if (e_wv && win_ready) begin
        for (int i = 0; i < int'(e_len); i++) void'(q.pop_front());
        m_win_pc = m_win_pc + 64'(8 * e_len);
      end
      if (rsp_valid) begin
        e = inflight.pop_front();
        if (!e.stale) q.push_back(word_at(e.addr));
      end
      if (e_rv && req_ready) begin
        inflight.push_back('{m_fetch_pc, 1'b0, cyc + lat});
        m_fetch_pc = m_fetch_pc + 64'd8;
      end
    end
  endtask

  // One clock: drive at posedge+1, check and advance the model at negedge.
  task automatic cycle(input bit do_flush = 1'b0, input logic [63:0] fpc = 64'h0);
    drive(do_flush, fpc);
    @(negedge clk);
    check_outputs();
    update_model();
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic model_reset();
    q.delete();
    inflight.delete();
    m_fetch_pc = RESET_PC;
    m_win_pc   = RESET_PC;
  endtask

  initial begin
    int  rel_cyc;
    bit  found;
    rst_n = 1'b0; flush = 1'b0; flush_pc = '0; req_ready = 1'b0;
    rsp_valid = 1'b0; rsp_data = '0; win_ready = 1'b0;
    cyc = 0; lat = 1; ready_pct = 100; rsp_pct = 100; wr_pct = 100;
    model_reset();
    @(posedge clk); #1;
    cycle(); cycle();

    // Phase A: len-1 stream, memory always ready, 1-cycle latency.
    rst_n = 1'b1;
    rel_cyc = cyc;
    repeat (30) cycle();
    chk("first_win_valid_latency", 64'(first_wv_cyc - rel_cyc), 64'd2);
    chk("phaseA_win_pc", win_pc, 64'd224);

    // Phase C: decoder stalls; credits stop fetch with the queue full.
    wr_pct = 0;
    repeat (20) cycle();
    chk("stall_req_valid", req_valid, 1'b0);
    chk("stall_longs4", longs[4], word_at(m_win_pc + 64'd32));
    wr_pct = 100;
    repeat (10) cycle();

    // Phase D: flush to 0x1000 with three in flight and a same-cycle response.
    lat = 3;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      if (inflight.size() == 3 && inflight[0].due <= cyc) found = 1'b1;
      else cycle();
    end
    chk("flush_setup_found", found, 1'b1);
    cycle(1'b1, 64'h1000);
    flush = 1'b0;
    #1;
    chk("flush_req_addr", req_addr, 64'h1000);
    chk("flush_req_valid", req_valid, 1'b1);

    // Phase B: length-5 instructions from region 1.
    lat = 1; wr_pct = 70;
    repeat (40) cycle();

    // Phase E: randomized mixed lengths, latencies, stalls and flushes.
    ready_pct = 70; rsp_pct = 80; wr_pct = 60;
    cycle(1'b1, 64'h2000);
    for (int i = 0; i < 400; i++) begin
      lat = $urandom_range(1, 4);
      if ($urandom_range(0, 99) < 3)
        cycle(1'b1, 64'h2000 + 64'(8 * $urandom_range(0, 255)));
      else
        cycle();
    end

    // Phase F: reset mid-stream with five longs resident.
    lat = 1; ready_pct = 100; rsp_pct = 100; wr_pct = 0;
    cycle(1'b1, 64'h0);
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (q.size() == 5) found = 1'b1;
      else cycle();
    end
    chk("reset_setup_found", found, 1'b1);
    #1;
    rst_n = 1'b0; rsp_valid = 1'b0; flush = 1'b0;
    #1;
    model_reset();
    chk("rst_req_valid", req_valid, 1'b0);
    chk("rst_win_valid", win_valid, 1'b0);
    chk("rst_win_pc", win_pc, RESET_PC);
    chk("rst_req_addr", req_addr, RESET_PC);
    for (int i = 0; i < 5; i++) chk($sformatf("rst_longs%0d", i), longs[i], 64'h0);
    @(posedge clk); #1;
    cyc++;
    cycle();
    rst_n = 1'b1;
    wr_pct = 100;
    #1;
    chk("restart_req_valid", req_valid, 1'b1);
    chk("restart_req_addr", req_addr, RESET_PC);
    repeat (15) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
